// File: rtl/mem_arbiter.sv
// mem_arbiter
//   Two-port arbiter (instruction fetch + data) in front of a single-port memory.
//   Only one memory transaction is outstanding at a time. Data normally has
//   priority. Fetch is forced through once STARVE_MAX data grants have been
//   issued while fetch was requesting.
//
// Ports
//   clk, rst            clock, asynchronous active-high reset
//   if_req/if_addr      fetch request, held until if_ack
//   if_ack/if_rdata     one-cycle completion pulse, registered fetch data
//   d_req/d_we/d_be/    data request, held with its fields until d_ack
//   d_addr/d_wdata
//   d_ack/d_rdata       one-cycle completion pulse, registered read data
//   if_stall/d_stall    combinational: request pending and not acked this cycle
//   mem_req/mem_we/     registered memory request, stable until mem_ack
//   mem_be/mem_addr/
//   mem_wdata
//   mem_ack/mem_rdata   one-cycle memory completion with read data
//
// States
//   IDLE   | no transaction outstanding; arbitrate eligible requests
//   I_BUSY | fetch transaction outstanding, waiting for mem_ack
//   D_BUSY | data transaction outstanding, waiting for mem_ack

module mem_arbiter #(
    parameter int AW         = 32,
    parameter int DW         = 32,
    parameter int STARVE_MAX = 4
) (
    input  logic            clk,
    input  logic            rst,

    input  logic            if_req,
    input  logic [AW-1:0]   if_addr,
    output logic            if_ack,
    output logic [DW-1:0]   if_rdata,

    input  logic            d_req,
    input  logic            d_we,
    input  logic [DW/8-1:0] d_be,
    input  logic [AW-1:0]   d_addr,
    input  logic [DW-1:0]   d_wdata,
    output logic            d_ack,
    output logic [DW-1:0]   d_rdata,

    output logic            if_stall,
    output logic            d_stall,

    output logic            mem_req,
    output logic            mem_we,
    output logic [DW/8-1:0] mem_be,
    output logic [AW-1:0]   mem_addr,
    output logic [DW-1:0]   mem_wdata,
    input  logic            mem_ack,
    input  logic [DW-1:0]   mem_rdata
);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] I_BUSY = 2'd1;
    localparam logic [1:0] D_BUSY = 2'd2;

    localparam int SW = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);

    logic [1:0]    state;
    logic [SW-1:0] starve_cnt;
    logic          if_elig;
    logic          d_elig;
    logic          starved;
    logic          grant_if;
    logic          grant_d;

    // A port whose ack is high this cycle is still showing the request that
    // just completed, so it must not be granted again on it.
    assign if_elig  = if_req & ~if_ack;
    assign d_elig   = d_req & ~d_ack;
    assign if_stall = if_elig;
    assign d_stall  = d_elig;

    assign starved  = (starve_cnt == SW'(STARVE_MAX));
    assign grant_if = (state == IDLE) & if_elig & (starved | ~d_elig);
    assign grant_d  = (state == IDLE) & d_elig & ~grant_if;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            starve_cnt <= '0;
            mem_req    <= 1'b0;
            mem_we     <= 1'b0;
            mem_be     <= '0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            if_ack     <= 1'b0;
            d_ack      <= 1'b0;
            if_rdata   <= '0;
            d_rdata    <= '0;
        end else begin
            if_ack <= 1'b0;
            d_ack  <= 1'b0;
            case (state)
                IDLE: begin
                    // mem_ack seen here belongs to nothing and is ignored.
                    if (grant_if) begin
                        mem_req    <= 1'b1;
                        mem_we     <= 1'b0;
                        mem_be     <= '1;
                        mem_addr   <= if_addr;
                        mem_wdata  <= '0;
                        starve_cnt <= '0;
                        state      <= I_BUSY;
                    end else if (grant_d) begin
                        mem_req   <= 1'b1;
                        mem_we    <= d_we;
                        mem_be    <= d_be;
                        mem_addr  <= d_addr;
                        mem_wdata <= d_wdata;
                        if (if_req && !starved) begin
                            starve_cnt <= starve_cnt + SW'(1);
                        end
                        state     <= D_BUSY;
                    end
                end
                I_BUSY: begin
                    if (mem_ack) begin
                        mem_req  <= 1'b0;
                        if_ack   <= 1'b1;
                        if_rdata <= mem_rdata;
                        state    <= IDLE;
                    end
                end
                D_BUSY: begin
                    if (mem_ack) begin
                        mem_req <= 1'b0;
                        d_ack   <= 1'b1;
                        if (!mem_we) begin
                            d_rdata <= mem_rdata;
                        end
                        state   <= IDLE;
                    end
                end
                default: begin
                    mem_req <= 1'b0;
                    state   <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter
//   Randomised and directed stimulus for mem_arbiter. A behavioural model
//   predicts every memory grant and every completion from the arbitration
//   rules; a monitor pops those predictions whenever the DUT shows a grant or
//   an ack and compares. A small memory responder returns data with random
//   latency and occasionally injects stray mem_ack pulses.

module tb_mem_arbiter;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int BW = DW / 8;
    localparam int SMAX = 4;

    logic          clk = 1'b0;
    logic          clk_run = 1'b1;
    logic          rst = 1'b1;
    logic          if_req = 1'b0;
    logic [AW-1:0] if_addr = '0;
    logic          if_ack;
    logic [DW-1:0] if_rdata;
    logic          d_req = 1'b0;
    logic          d_we = 1'b0;
    logic [BW-1:0] d_be = '0;
    logic [AW-1:0] d_addr = '0;
    logic [DW-1:0] d_wdata = '0;
    logic          d_ack;
    logic [DW-1:0] d_rdata;
    logic          if_stall;
    logic          d_stall;
    logic          mem_req;
    logic          mem_we;
    logic [BW-1:0] mem_be;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic          mem_ack = 1'b0;
    logic [DW-1:0] mem_rdata = '0;

    mem_arbiter #(.AW(AW), .DW(DW), .STARVE_MAX(SMAX)) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_ack(if_ack), .if_rdata(if_rdata),
        .d_req(d_req), .d_we(d_we), .d_be(d_be), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_ack(d_ack), .d_rdata(d_rdata),
        .if_stall(if_stall), .d_stall(d_stall),
        .mem_req(mem_req), .mem_we(mem_we), .mem_be(mem_be), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata)
    );

    always begin
        #5;
        if (clk_run) clk = ~clk;
    end

    int checks = 0;
    int errors = 0;

    function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endfunction

    // ---------------- reference model ----------------
    typedef struct {
        int            port;   // 1 = fetch, 2 = data
        logic          we;
        logic [BW-1:0] be;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
    } grant_t;

    typedef struct {
        int            port;
        logic          rd;
        logic [DW-1:0] rdata;
    } ack_t;

    grant_t grant_q[$];
    ack_t   ack_q[$];

    int            m_owner = 0;
    int            m_starve = 0;
    logic          m_we = 1'b0;
    logic          m_if_ack = 1'b0;
    logic          m_d_ack = 1'b0;
    logic [DW-1:0] exp_if_rdata = '0;
    logic [DW-1:0] exp_d_rdata = '0;

    initial begin
        grant_t g;
        ack_t   a;
        logic   nia;
        logic   nda;
        logic   ie;
        logic   de;
        forever begin
            @(posedge clk or posedge rst);
            if (rst) begin
                m_owner = 0; m_starve = 0; m_we = 1'b0;
                m_if_ack = 1'b0; m_d_ack = 1'b0;
                exp_if_rdata = '0; exp_d_rdata = '0;
                grant_q.delete(); ack_q.delete();
            end else begin
                nia = 1'b0; nda = 1'b0;
                if (m_owner != 0) begin
                    if (mem_ack) begin
                        a.port = m_owner;
                        a.rd = (m_owner == 1) || !m_we;
                        a.rdata = mem_rdata;
                        ack_q.push_back(a);
                        if (m_owner == 1) begin
                            nia = 1'b1; exp_if_rdata = mem_rdata;
                        end else begin
                            nda = 1'b1;
                            if (!m_we) exp_d_rdata = mem_rdata;
                        end
                        m_owner = 0;
                    end
                end else begin
                    ie = if_req && !m_if_ack;
                    de = d_req && !m_d_ack;
                    if (ie && (m_starve == SMAX || !de)) begin
                        g.port = 1; g.we = 1'b0; g.be = '1; g.addr = if_addr; g.wdata = '0;
                        grant_q.push_back(g);
                        m_starve = 0; m_owner = 1;
                    end else if (de) begin
                        g.port = 2; g.we = d_we; g.be = d_be; g.addr = d_addr; g.wdata = d_wdata;
                        grant_q.push_back(g);
                        m_we = d_we;
                        if (if_req && m_starve < SMAX) m_starve++;
                        m_owner = 2;
                    end
                end
                m_if_ack = nia;
                m_d_ack = nda;
            end
        end
    end

    // ---------------- monitor ----------------
    initial begin
        grant_t cur;
        grant_t g;
        ack_t   a;
        logic   prev_req;
        logic   rise;
        prev_req = 1'b0;
        cur.port = 0; cur.we = 1'b0; cur.be = '0; cur.addr = '0; cur.wdata = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                prev_req = 1'b0;
            end else begin
                rise = mem_req && !prev_req;
                if (rise) begin
                    if (grant_q.size() == 0) begin
                        chk("unexpected_grant", {32'h0, mem_addr}, 64'h0);
                    end else begin
                        g = grant_q.pop_front();
                        cur = g;
                        chk("grant_we", mem_we, g.we);
                        chk("grant_be", mem_be, g.be);
                        chk("grant_addr", mem_addr, g.addr);
                        if (g.port == 2) chk("grant_wdata", mem_wdata, g.wdata);
                    end
                end else begin
                    if (grant_q.size() != 0) begin
                        g = grant_q.pop_front();
                        chk("missing_grant", mem_req, 1'b1);
                    end
                    if (mem_req) chk("held_fields", {mem_we, mem_be, mem_addr},
                                     {cur.we, cur.be, cur.addr});
                end
                if (if_ack || d_ack) begin
                    if (ack_q.size() == 0) begin
                        chk("unexpected_ack", {if_ack, d_ack}, 2'b00);
                    end else begin
                        a = ack_q.pop_front();
                        chk("ack_port", {if_ack, d_ack}, (a.port == 1) ? 2'b10 : 2'b01);
                        if (a.port == 1) chk("if_rdata_on_ack", if_rdata, a.rdata);
                        else if (a.rd) chk("d_rdata_on_ack", d_rdata, a.rdata);
                    end
                end else if (ack_q.size() != 0) begin
                    a = ack_q.pop_front();
                    chk("missing_ack", {if_ack, d_ack}, (a.port == 1) ? 2'b10 : 2'b01);
                end
                chk("if_rdata_hold", if_rdata, exp_if_rdata);
                chk("d_rdata_hold", d_rdata, exp_d_rdata);
                chk("if_stall", if_stall, if_req && !m_if_ack);
                chk("d_stall", d_stall, d_req && !m_d_ack);
                prev_req = mem_req;
            end
        end
    end

    // ---------------- memory responder ----------------
    int            lat_lo = 1;
    int            lat_hi = 4;
    logic          use_fix = 1'b0;
    logic [DW-1:0] fix_rdata = '0;
    int            stray_tok = 0;
    int            stray_seen = 0;
    int            wait_cnt = -1;

    initial begin
        forever begin
            @(posedge clk);
            #2;
            mem_ack = 1'b0;
            if (wait_cnt > 0) begin
                wait_cnt--;
                if (wait_cnt == 0) begin
                    mem_ack = 1'b1;
                    mem_rdata = use_fix ? fix_rdata : DW'($urandom);
                    wait_cnt = -1;
                end
            end else if (mem_req) begin
                wait_cnt = $urandom_range(lat_hi, lat_lo);
            end else if (stray_tok != stray_seen) begin
                stray_seen = stray_tok;
                mem_ack = 1'b1;
                mem_rdata = DW'($urandom);
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_ack(input int port, input int budget);
        bit seen;
        seen = 1'b0;
        for (int n = 0; n < budget && !seen; n++) begin
            @(posedge clk);
            #1;
            if ((port == 1 && if_ack) || (port == 2 && d_ack)) seen = 1'b1;
        end
        if (!seen) begin
            checks++;
            errors++;
            $display("FAIL wait_ack_port%0d: got no ack, expected ack within %0d cycles", port, budget);
        end
    endtask

    int if_gap = 0;
    int d_gap = 0;

    initial begin
        int  n_d;
        int  n_ack;
        bit  done;
        bit  seen;

        rst = 1'b1;
        idle(3);
        chk("rst_mem_req", mem_req, 1'b0);
        chk("rst_mem_addr", mem_addr, '0);
        chk("rst_if_ack", if_ack, 1'b0);
        chk("rst_d_ack", d_ack, 1'b0);
        chk("rst_if_rdata", if_rdata, '0);
        chk("rst_d_rdata", d_rdata, '0);

        // single fetch, first edge after reset release
        lat_lo = 3; lat_hi = 3; use_fix = 1'b1; fix_rdata = 32'h00500093;
        rst = 1'b0;
        if_req = 1'b1; if_addr = 32'h100;
        idle(1);
        chk("fetch_mem_req", mem_req, 1'b1);
        chk("fetch_mem_addr", mem_addr, 32'h100);
        chk("fetch_mem_we", mem_we, 1'b0);
        wait_ack(1, 20);
        chk("fetch_if_rdata", if_rdata, 32'h00500093);
        if_req = 1'b0;
        idle(2);

        // collision: data first, then fetch
        lat_lo = 1; lat_hi = 4; fix_rdata = 32'h11112222;
        if_req = 1'b1; if_addr = 32'h300;
        d_req = 1'b1; d_we = 1'b0; d_be = '1; d_addr = 32'h2000; d_wdata = '0;
        idle(1);
        chk("coll_data_first", mem_addr, 32'h2000);
        wait_ack(2, 20);
        chk("coll_if_stall", if_stall, 1'b1);
        d_req = 1'b0;
        wait_ack(1, 20);
        if_req = 1'b0;
        idle(2);

        // write
        d_req = 1'b1; d_we = 1'b1; d_be = 4'b0011; d_addr = 32'h2004; d_wdata = 32'hDEADBEEF;
        idle(1);
        chk("wr_mem_we", mem_we, 1'b1);
        chk("wr_mem_be", mem_be, 4'b0011);
        chk("wr_mem_addr", mem_addr, 32'h2004);
        chk("wr_mem_wdata", mem_wdata, 32'hDEADBEEF);
        wait_ack(2, 20);
        chk("wr_d_rdata_kept", d_rdata, 32'h11112222);
        d_req = 1'b0; d_we = 1'b0;
        idle(2);

        // request held through its ack cycle is not re-granted
        d_req = 1'b1; d_addr = 32'h2008;
        wait_ack(2, 20);
        idle(1);
        chk("held_no_regrant", mem_req, 1'b0);
        d_req = 1'b0;
        idle(2);

        // stray mem_ack while idle
        stray_tok++;
        n_ack = 0;
        for (int k = 0; k < 5; k++) begin
            idle(1);
            if (if_ack || d_ack) n_ack++;
        end
        chk("stray_no_ack", n_ack, 0);

        // starvation, two rounds (second shows the count restarts at zero)
        use_fix = 1'b0;
        for (int r = 0; r < 2; r++) begin
            idle(2);
            n_d = 0; done = 1'b0;
            if_req = 1'b1; if_addr = 32'h400 + AW'(r * 4);
            d_req = 1'b1; d_we = 1'b0; d_addr = 32'h3000;
            for (int k = 0; k < 300 && !done; k++) begin
                idle(1);
                if (if_ack) done = 1'b1;
                else if (d_ack) begin
                    n_d++; d_addr = d_addr + 4; if_req = 1'b0;
                end else if_req = 1'b1;
            end
            chk("starve_fetch_done", done, 1'b1);
            chk("starve_data_grants", n_d, SMAX);
            if_req = 1'b0; d_req = 1'b0;
            idle(12);
        end

        // random traffic
        for (int cyc = 0; cyc < 3000; cyc++) begin
            idle(1);
            if (if_req) begin
                if (if_ack) begin
                    if ($urandom_range(0, 2) == 0) if_addr = $urandom;
                    else begin if_req = 1'b0; if_gap = $urandom_range(0, 3); end
                end else if ($urandom_range(0, 39) == 0) if_req = 1'b0;
            end else if (if_gap > 0) if_gap--;
            else if ($urandom_range(0, 1) == 1) begin
                if_req = 1'b1; if_addr = $urandom;
            end
            if (d_req) begin
                if (d_ack) begin
                    if ($urandom_range(0, 2) == 0) begin
                        d_we = 1'($urandom); d_be = BW'($urandom); d_addr = $urandom; d_wdata = $urandom;
                    end else begin d_req = 1'b0; d_gap = $urandom_range(0, 3); end
                end else if ($urandom_range(0, 39) == 0) d_req = 1'b0;
            end else if (d_gap > 0) d_gap--;
            else if ($urandom_range(0, 1) == 1) begin
                d_req = 1'b1; d_we = 1'($urandom); d_be = BW'($urandom);
                d_addr = $urandom; d_wdata = $urandom;
            end
            if ($urandom_range(0, 19) == 0) stray_tok++;
        end
        if_req = 1'b0; d_req = 1'b0;
        idle(20);

        // reset in the middle of a data transaction with the clock stopped
        lat_lo = 8; lat_hi = 8; use_fix = 1'b1; fix_rdata = 32'h0BADF00D;
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h5000;
        seen = 1'b0;
        for (int k = 0; k < 20 && !seen; k++) begin
            idle(1);
            if (mem_req) seen = 1'b1;
        end
        chk("rst_mid_busy", seen, 1'b1);
        d_req = 1'b0;
        @(negedge clk);
        clk_run = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        chk("async_rst_mem_req", mem_req, 1'b0);
        chk("async_rst_mem_addr", mem_addr, '0);
        chk("async_rst_d_ack", d_ack, 1'b0);
        chk("async_rst_d_rdata", d_rdata, '0);
        chk("async_rst_if_rdata", if_rdata, '0);
        #5;
        rst = 1'b0;
        #5;
        clk_run = 1'b1;
        n_ack = 0;
        for (int k = 0; k < 15; k++) begin
            idle(1);
            if (if_ack || d_ack) n_ack++;
        end
        chk("late_ack_ignored", n_ack, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
